noc_pkt_injector: RTL and testbench

- Traffic source on a router's local port. It converts a one-cycle send_en pulse into one complete wormhole packet: head, (PKT_LEN-2) body flits, tail.
- It drives the router's local-input valid/ready interface.
- Payloads are deterministic, so a downstream checker can validate them. The tail carries an XOR checksum of the body flits.

---
 rtl/noc_pkg.sv | 31 +++
 rtl/noc_flit_builder.sv | 42 ++++
 rtl/noc_pkt_injector.sv | 136 +++++++++++++
 tb/tb_noc_pkt_injector.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit format, FSM encoding and head-field layout for the NoC
package noc_pkg;

    localparam int FLIT_W  = 34;
    localparam int COORD_W = 2;

    typedef enum logic [1:0] {
        BODY = 2'b00,
        HEAD = 2'b01,
        TAIL = 2'b10
    } flit_type_e;

    typedef struct packed {
        flit_type_e  ftype;
        logic [31:0] data;
    } flit_t;

    // Bit positions of the head-flit fields inside flit_t.data
    localparam int HEAD_ID_LSB  = 24;
    localparam int HEAD_LEN_LSB = 16;
    localparam int HEAD_DX_LSB  = 6;
    localparam int HEAD_DY_LSB  = 4;
    localparam int HEAD_SX_LSB  = 2;
    localparam int HEAD_SY_LSB  = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HEAD = 2'd1;
    localparam logic [1:0] ST_BODY = 2'd2;
    localparam logic [1:0] ST_TAIL = 2'd3;

endpackage

// File: rtl/noc_flit_builder.sv
// rtl/noc_flit_builder.sv - combinational flit formatter driven purely from injector flops
module noc_flit_builder
    import noc_pkg::*;
#(
    parameter int PKT_LEN = 4,
    parameter int SRC_X   = 0,
    parameter int SRC_Y   = 0
) (
    input  logic [1:0]         i_state,
    input  logic [7:0]         i_pkt_id,
    input  logic [7:0]         i_index,
    input  logic [COORD_W-1:0] i_dst_x,
    input  logic [COORD_W-1:0] i_dst_y,
    input  logic [31:0]        i_csum,
    output flit_t              o_flit
);

    always_comb begin
        o_flit = '0;
        case (i_state)
            ST_HEAD: begin
                o_flit.ftype                          = HEAD;
                o_flit.data[HEAD_ID_LSB  +: 8]        = i_pkt_id;
                o_flit.data[HEAD_LEN_LSB +: 8]        = 8'(PKT_LEN);
                o_flit.data[HEAD_DX_LSB  +: COORD_W]  = i_dst_x;
                o_flit.data[HEAD_DY_LSB  +: COORD_W]  = i_dst_y;
                o_flit.data[HEAD_SX_LSB  +: COORD_W]  = COORD_W'(SRC_X);
                o_flit.data[HEAD_SY_LSB  +: COORD_W]  = COORD_W'(SRC_Y);
            end
            ST_BODY: begin
                o_flit.ftype = BODY;
                o_flit.data  = {i_pkt_id, 24'(i_index)};
            end
            ST_TAIL: begin
                o_flit.ftype = TAIL;
                o_flit.data  = i_csum;
            end
            default: o_flit = '0;
        endcase
    end

endmodule

// File: rtl/noc_pkt_injector.sv
// rtl/noc_pkt_injector.sv - turns send_en pulses into head/body/tail wormhole packets
module noc_pkt_injector
    import noc_pkg::*;
#(
    parameter int PKT_LEN = 4,
    parameter int SRC_X   = 0,
    parameter int SRC_Y   = 0
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               send_en,
    input  logic [COORD_W-1:0] dst_x,
    input  logic [COORD_W-1:0] dst_y,
    output logic [FLIT_W-1:0]  out_flit,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic [7:0]         pkt_cnt,
    output logic [7:0]         drop_cnt
);

    localparam logic [7:0] LAST_BODY = 8'(PKT_LEN - 2);

    logic [1:0]         r_state;
    logic [7:0]         r_pkt_id;
    logic [7:0]         r_index;
    logic [COORD_W-1:0] r_dst_x;
    logic [COORD_W-1:0] r_dst_y;
    logic               r_pend;
    logic [COORD_W-1:0] r_pend_x;
    logic [COORD_W-1:0] r_pend_y;
    logic [31:0]        r_csum;
    logic [7:0]         r_pkt_cnt;
    logic [7:0]         r_drop_cnt;

    flit_t w_flit;
    logic  w_xfer;
    logic  w_tail_take;

    assign w_xfer = (r_state != ST_IDLE) && out_ready;
    // A request landing on the final tail handshake with nothing queued starts the next packet directly
    assign w_tail_take = (r_state == ST_TAIL) && w_xfer && !r_pend && send_en;

    noc_flit_builder #(
        .PKT_LEN (PKT_LEN),
        .SRC_X   (SRC_X),
        .SRC_Y   (SRC_Y)
    ) u_builder (
        .i_state  (r_state),
        .i_pkt_id (r_pkt_id),
        .i_index  (r_index),
        .i_dst_x  (r_dst_x),
        .i_dst_y  (r_dst_y),
        .i_csum   (r_csum),
        .o_flit   (w_flit)
    );

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state    <= ST_IDLE;
            r_pkt_id   <= '0;
            r_index    <= '0;
            r_dst_x    <= '0;
            r_dst_y    <= '0;
            r_pend     <= 1'b0;
            r_pend_x   <= '0;
            r_pend_y   <= '0;
            r_csum     <= '0;
            r_pkt_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (send_en) begin
                        r_dst_x <= dst_x;
                        r_dst_y <= dst_y;
                        r_state <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (w_xfer) begin
                        r_index <= 8'd1;
                        r_csum  <= '0;
                        r_state <= (PKT_LEN == 2) ? ST_TAIL : ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (w_xfer) begin
                        r_csum <= r_csum ^ w_flit.data;
                        if (r_index == LAST_BODY) begin
                            r_state <= ST_TAIL;
                        end else begin
                            r_index <= r_index + 8'd1;
                        end
                    end
                end
                ST_TAIL: begin
                    if (w_xfer) begin
                        r_pkt_cnt <= r_pkt_cnt + 8'd1;
                        r_pkt_id  <= r_pkt_id + 8'd1;
                        if (r_pend) begin
                            r_dst_x <= r_pend_x;
                            r_dst_y <= r_pend_y;
                            r_pend  <= 1'b0;
                            r_state <= ST_HEAD;
                        end else if (send_en) begin
                            r_dst_x <= dst_x;
                            r_dst_y <= dst_y;
                            r_state <= ST_HEAD;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if ((r_state != ST_IDLE) && send_en && !w_tail_take) begin
                if (!r_pend) begin
                    r_pend   <= 1'b1;
                    r_pend_x <= dst_x;
                    r_pend_y <= dst_y;
                end else if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
        end
    end

    assign out_flit  = w_flit;
    assign out_valid = (r_state != ST_IDLE);
    assign busy      = (r_state != ST_IDLE) || r_pend;
    assign pkt_cnt   = r_pkt_cnt;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_noc_pkt_injector.sv
// tb/tb_noc_pkt_injector.sv - scoreboard bench for the packet injector
module tb_noc_pkt_injector;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        send_en = 1'b0;
    logic [1:0]  dst_x = 2'd0;
    logic [1:0]  dst_y = 2'd0;
    logic [33:0] out_flit;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic [7:0]  pkt_cnt;
    logic [7:0]  drop_cnt;

    logic        send2 = 1'b0;
    logic [33:0] flit2;
    logic        valid2;
    logic        busy2;
    logic [7:0]  pcnt2;
    logic [7:0]  dcnt2;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [33:0] q[$];
    logic [7:0]  m_id = 8'd0;
    logic [7:0]  m_pkts = 8'd0;
    int          m_drops = 0;
    int          cyc = 0;
    int          last_cyc = -10;
    logic        last_tail = 1'b0;
    int          b2b_seen = 0;
    logic        hold = 1'b0;
    logic [33:0] held;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    noc_pkt_injector #(.PKT_LEN(4), .SRC_X(0), .SRC_Y(0)) u_dut (
        .clk(clk), .nreset(nreset), .send_en(send_en), .dst_x(dst_x), .dst_y(dst_y),
        .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    noc_pkt_injector #(.PKT_LEN(2), .SRC_X(2), .SRC_Y(1)) u_dut2 (
        .clk(clk), .nreset(nreset), .send_en(send2), .dst_x(2'd3), .dst_y(2'd2),
        .out_flit(flit2), .out_valid(valid2), .out_ready(1'b1),
        .busy(busy2), .pkt_cnt(pcnt2), .drop_cnt(dcnt2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] dx, input logic [1:0] dy);
        send_en = 1'b1;
        dst_x   = dx;
        dst_y   = dy;
        tick();
        send_en = 1'b0;
    endtask

    task automatic expect_pkt(input logic [1:0] dx, input logic [1:0] dy);
        logic [31:0] x;
        logic [31:0] d;
        x = 32'h0;
        q.push_back({2'b01, m_id, 8'd4, 8'd0, dx, dy, 4'b0000});
        for (int k = 1; k <= 2; k++) begin
            d = {m_id, 24'(k)};
            x = x ^ d;
            q.push_back({2'b00, d});
        end
        q.push_back({2'b10, x});
        m_id   = m_id + 8'd1;
        m_pkts = m_pkts + 8'd1;
    endtask

    task automatic add_drop();
        if (m_drops < 255) m_drops++;
    endtask

    task automatic wait_idle(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            if (!busy && q.size() == 0) done = 1'b1;
            else tick();
        end
        if (!done) check({tag, "_timeout"}, 64'(q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        logic [33:0] e;
        if (!nreset) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_flit", 64'(out_flit), 64'(held));
            end
            hold = out_valid && !out_ready;
            held = out_flit;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("sb_underflow", 64'(q.size()), 64'd1);
                end else begin
                    e = q.pop_front();
                    check("sb_flit", 64'(out_flit), 64'(e));
                    if (e[33:32] == 2'b01 && last_tail && cyc == last_cyc + 1) b2b_seen++;
                end
                last_tail = (out_flit[33:32] == 2'b10);
                last_cyc  = cyc;
            end
        end
    end

    initial begin
        int b0;
        // reset state
        nreset = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_flit", 64'(out_flit), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        nreset = 1'b1;
        tick();

        // single packet, head one cycle after the request
        expect_pkt(2'd1, 2'd1);
        send(2'd1, 2'd1);
        check("head_latency_valid", 64'(out_valid), 64'd1);
        check("head_data", 64'(out_flit[31:0]), 64'h0004_0050);
        wait_idle("single");
        check("single_pkt_cnt", 64'(pkt_cnt), 64'(m_pkts));
        check("single_busy", 64'(busy), 64'd0);

        // PKT_LEN=2 instance: head then zero tail
        send2 = 1'b1;
        tick();
        send2 = 1'b0;
        check("len2_head_valid", 64'(valid2), 64'd1);
        check("len2_head", 64'(flit2), 64'({2'b01, 8'd0, 8'd2, 8'd0, 2'd3, 2'd2, 2'd2, 2'd1}));
        tick();
        check("len2_tail", 64'(flit2), 64'({2'b10, 32'h0}));
        tick();
        check("len2_idle", 64'(valid2), 64'd0);
        check("len2_pkt_cnt", 64'(pcnt2), 64'd1);

        // backpressure on the first body flit
        expect_pkt(2'd2, 2'd3);
        send(2'd2, 2'd3);
        tick();
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
        wait_idle("bp");
        check("bp_pkt_cnt", 64'(pkt_cnt), 64'(m_pkts));

        // back-to-back: request at head, one pending, one dropped
        b0 = b2b_seen;
        expect_pkt(2'd1, 2'd0);
        send(2'd1, 2'd0);
        expect_pkt(2'd3, 2'd3);
        send(2'd3, 2'd3);
        send(2'd2, 2'd2);
        add_drop();
        wait_idle("b2b");
        check("b2b_no_gap", 64'(b2b_seen - b0), 64'd1);
        check("b2b_drop_cnt", 64'(drop_cnt), 64'(m_drops));
        check("b2b_pkt_cnt", 64'(pkt_cnt), 64'(m_pkts));

        // request on the tail handshake with nothing pending
        b0 = b2b_seen;
        expect_pkt(2'd0, 2'd1);
        send(2'd0, 2'd1);
        repeat (3) tick();
        expect_pkt(2'd1, 2'd2);
        send(2'd1, 2'd2);
        wait_idle("tailreq");
        check("tailreq_no_gap", 64'(b2b_seen - b0), 64'd1);
        check("tailreq_drop_cnt", 64'(drop_cnt), 64'(m_drops));
        check("tailreq_pkt_cnt", 64'(pkt_cnt), 64'(m_pkts));

        // reset in the middle of a packet
        expect_pkt(2'd2, 2'd1);
        send(2'd2, 2'd1);
        tick();
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        q.delete();
        m_id = 8'd0;
        m_pkts = 8'd0;
        m_drops = 0;
        expect_pkt(2'd3, 2'd0);
        send(2'd3, 2'd0);
        wait_idle("midrst");

        // pkt_cnt and pkt_id wrap
        for (int i = 0; i < 255; i++) begin
            expect_pkt(2'(i), 2'(i >> 2));
            send(2'(i), 2'(i >> 2));
            wait_idle("wrap");
        end
        check("wrap_pkt_cnt", 64'(pkt_cnt), 64'(m_pkts));
        check("wrap_pkt_cnt_zero", 64'(pkt_cnt), 64'd0);

        // drop saturation while stalled: first extra request pends, the rest drop
        out_ready = 1'b0;
        expect_pkt(2'd1, 2'd1);
        send(2'd1, 2'd1);
        for (int i = 0; i < 301; i++) begin
            if (i == 0) begin
                expect_pkt(2'd2, 2'd2);
                send(2'd2, 2'd2);
            end else begin
                send(2'd0, 2'd0);
                add_drop();
            end
        end
        check("sat_drop_cnt", 64'(drop_cnt), 64'(m_drops));
        check("sat_drop_255", 64'(drop_cnt), 64'd255);
        out_ready = 1'b1;
        wait_idle("sat");
        check("sat_pkt_cnt", 64'(pkt_cnt), 64'(m_pkts));
        check("sb_drained", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
